// File: rtl/buf_cmd_pkg.sv
// rtl/buf_cmd_pkg.sv - shared command-stream constants for the buffer writer and executor
package buf_cmd_pkg;

    localparam int CMD_W = 40;

    localparam logic [1:0] OP_CLASS_REG  = 2'b01;
    localparam logic [1:0] OP_CLASS_MISC = 2'b10;

    localparam logic [5:0] MISC_NOP  = 6'd0;
    localparam logic [5:0] MISC_STB  = 6'd1;
    localparam logic [5:0] MISC_DONE = 6'd63;

    localparam logic [1:0] ADDR_HDR  = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_DONE = 2'd2;
    localparam logic [1:0] ADDR_THR  = 2'd3;

    localparam logic [7:0] OP_NOP  = {OP_CLASS_MISC, MISC_NOP};
    localparam logic [7:0] OP_DONE = {OP_CLASS_MISC, MISC_DONE};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } start_state_t;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [7:0] opcode, input logic [31:0] data);
        return {opcode, data};
    endfunction

endpackage

// File: rtl/buf_skid_fifo.sv
// rtl/buf_skid_fifo.sv - small power-of-two skid buffer holding command words
module buf_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 40,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/buf_cmd_writer.sv
// rtl/buf_cmd_writer.sv - host register writes to 40-bit command words with auto executor start
module buf_cmd_writer
    import buf_cmd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       host_addr,
    input  logic [31:0]      host_data,
    input  logic             host_stb,
    output logic             host_busy,
    input  logic             flush,
    input  logic             fifo_full,
    output logic [CMD_W-1:0] fifo_data,
    output logic             fifo_write,
    input  logic             exec_busy,
    output logic             exec_start,
    output logic [CNT_W-1:0] words_written,
    output logic             overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]       header;
    logic [CNT_W-1:0] threshold;
    logic [CNT_W-1:0] since_start;
    logic             done_armed;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    logic             wr_hdr;
    logic             wr_data;
    logic             wr_done;
    logic             wr_thr;
    logic             push_req;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] push_data;
    logic             thr_hit;

    start_state_t     state;
    start_state_t     state_next;
    logic [1:0]       run_cnt;
    logic             seen_busy;

    // Flush takes precedence over any host write in the same cycle.
    always_comb begin
        wr_hdr    = host_stb && !flush && (host_addr == ADDR_HDR);
        wr_data   = host_stb && !flush && (host_addr == ADDR_DATA);
        wr_done   = host_stb && !flush && (host_addr == ADDR_DONE);
        wr_thr    = host_stb && !flush && (host_addr == ADDR_THR);
        push_req  = wr_data || wr_done;
        push      = push_req && !full;
        pop       = !empty && !fifo_full;
        push_data = wr_done ? make_cmd(OP_DONE, 32'h0) : make_cmd(header, host_data);
        thr_hit   = (threshold != '0) && (since_start >= threshold);
    end

    assign host_busy  = full;
    assign fifo_write = pop;

    buf_skid_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W),
        .CW    (CW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (fifo_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            header    <= OP_NOP;
            threshold <= '0;
        end else begin
            if (wr_hdr) begin
                header <= host_data[7:0];
            end
            if (wr_thr) begin
                threshold <= CNT_W'(host_data);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!exec_busy && (thr_hit || (done_armed && empty))) begin
                    state_next = S_START;
                end
            end
            S_START: state_next = S_RUN;
            S_RUN: begin
                // Leave on busy falling, or if the executor never raised busy at all.
                if (seen_busy && !exec_busy) begin
                    state_next = S_IDLE;
                end else if (!seen_busy && !exec_busy && (run_cnt == 2'd3)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state         <= S_IDLE;
            exec_start    <= 1'b0;
            words_written <= '0;
            since_start   <= '0;
            done_armed    <= 1'b0;
            overflow      <= 1'b0;
            run_cnt       <= 2'd0;
            seen_busy     <= 1'b0;
        end else begin
            state      <= state_next;
            exec_start <= (state_next == S_START);

            if (pop) begin
                words_written <= words_written + 1'b1;
            end

            if (state == S_START) begin
                since_start <= {{(CNT_W-1){1'b0}}, pop};
            end else if (pop && (since_start != '1)) begin
                since_start <= since_start + 1'b1;
            end

            if (wr_done && push) begin
                done_armed <= 1'b1;
            end else if (state == S_START) begin
                done_armed <= 1'b0;
            end

            if (push_req && full) begin
                overflow <= 1'b1;
            end

            if (state != S_RUN) begin
                run_cnt   <= 2'd0;
                seen_busy <= 1'b0;
            end else if (exec_busy) begin
                seen_busy <= 1'b1;
            end else if (run_cnt != 2'd3) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule
